wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter MAT_LANES, default 4, giving the number of 32-bit lanes in a matrix result and the number of register-file beats per matrix write.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, giving the number of lost arbitration cycles after which the matrix requester wins.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 s_valid  input  1  scalar writeback request, from the MEM/WB stage.
REQ-006 s_rd  input  5  scalar destination register.
REQ-007 s_data  input  32  scalar write data: the ALU or memory result, already selected.
REQ-008 m_valid  input  1  matrix writeback request; held with m_rd and m_data until m_ready.
REQ-009 m_rd  input  5  destination of lane 0; lane k goes to register (m_rd+k) mod 32.
REQ-010 m_data  input  32*MAT_LANES  matrix result; lane k is bits [32k+31:32k].
REQ-011 m_ready  output  1  combinational one-cycle grant pulse for a matrix request.
REQ-012 stall_o  output  1  combinational; upstream SHALL hold s_* while it is high.
REQ-013 rf_we  output  1  registered register-file write enable.
REQ-014 rf_waddr  output  5  registered write address.
REQ-015 rf_wdata  output  32  registered write data.
REQ-016 busy  output  1  high while in state MAT.

Function
REQ-017 The FSM SHALL have two states: IDLE and MAT. It SHALL also hold a beat counter of width clog2(MAT_LANES), a saturating starve counter, and a lane buffer.
REQ-018 In IDLE, mgrant SHALL be m_valid & (!s_valid | starve_cnt==STARVE_LIMIT). m_ready SHALL equal mgrant. m_ready SHALL be 0 in MAT.
REQ-019 stall_o SHALL be (state==MAT) | (mgrant & s_valid).
REQ-020 A scalar request SHALL be accepted when s_valid & !stall_o. Acceptance in cycle T SHALL register rf_we=1, rf_waddr=s_rd, rf_wdata=s_data, visible in cycle T+1.
REQ-021 A matrix grant in cycle T SHALL register beat 0 (m_rd, lane 0), visible in cycle T+1. It SHALL latch m_rd and lanes 1..MAT_LANES-1 into the buffer, set beat=1, and enter MAT.
REQ-022 In MAT, each cycle SHALL register beat k: address (m_rd+k) mod 32 (5-bit wrap), data lane k.
REQ-023 In MAT, after the MAT_LANES-1 beat is registered, the FSM SHALL return to IDLE. Beats therefore appear in cycles T+1..T+MAT_LANES, and MAT lasts MAT_LANES-1 cycles.
REQ-024 When MAT_LANES==1, a grant SHALL stay in IDLE; the only stall is the grant cycle itself when s_valid is high.
REQ-025 Any write whose address is 0 SHALL register rf_we=0. rf_waddr and rf_wdata SHALL still update, and a matrix beat SHALL still consume its cycle.
REQ-026 In a cycle with no accepted write, rf_we SHALL register 0. rf_waddr and rf_wdata SHALL hold their previous values.
REQ-027 starve_cnt SHALL increment, saturating at STARVE_LIMIT, in each IDLE cycle where m_valid & s_valid & !mgrant. It SHALL clear on mgrant and otherwise hold.
REQ-028 Simultaneous s_valid and m_valid with starve_cnt<STARVE_LIMIT SHALL accept the scalar request. With starve_cnt==STARVE_LIMIT, the matrix request SHALL win and the scalar request SHALL stall.
REQ-029 s_valid in MAT SHALL not be accepted. It SHALL be accepted in the first IDLE cycle unless mgrant is high in that cycle.
REQ-030 m_valid deasserting before m_ready is a protocol violation; the block SHALL need no defined behaviour for it.

Reset
REQ-031 While rst=1, regardless of clk: state=IDLE, beat=0, starve_cnt=0, buffer=0, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0.
REQ-032 m_ready and stall_o SHALL be 0 during reset.
REQ-033 Reset asserted mid-MAT SHALL abort the remaining beats. After release, no further beats of that burst SHALL be written.

Verification
REQ-034 Scalar only: s_valid=1, s_rd=5, s_data=0xDEADBEEF in cycle T -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; stall_o=0 throughout.
REQ-035 Matrix only: m_rd=8, m_data=0x44444444_33333333_22222222_11111111 at T -> m_ready=1 at T.
- Writes (8,0x11111111), (9,0x22222222), (10,0x33333333), (11,0x44444444) in T+1..T+4.
- busy=1 in T+1..T+3.
REQ-036 Wrap and x0: m_rd=30 -> beats to 30, 31, 0, 1, with rf_we=0 on the beat to address 0. Also s_rd=0 -> rf_we=0.
REQ-037 Contention: s_valid=1 every cycle with varying s_rd, plus m_valid=1 from T. Scalar requests are accepted T..T+7. Matrix is granted at T+8, with stall_o=1 in T+8..T+11. Scalar resumes at T+12.
REQ-038 Reset mid-burst: assert rst in T+2 of a matrix burst -> all outputs 0 immediately. After release, no beats are written for addresses m_rd+2 or m_rd+3.
REQ-039 Back-to-back: a second m_valid already high as MAT ends, with s_valid=0 -> grant in the first IDLE cycle, and beats continue with no bubble.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges scalar MEM/WB writebacks with
// multi-lane matrix results, serialising each matrix result one lane per cycle.
module wb_port_arbiter #(
  parameter int unsigned MAT_LANES    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  input  logic [4:0]                s_rd,
  input  logic [31:0]               s_data,
  input  logic                      m_valid,
  input  logic [4:0]                m_rd,
  input  logic [32*MAT_LANES-1:0]   m_data,
  output logic                      m_ready,
  output logic                      stall_o,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [31:0]               rf_wdata,
  output logic                      busy
);

  localparam int unsigned BW = (MAT_LANES > 1) ? $clog2(MAT_LANES) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(MAT_LANES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {
    IDLE,
    MAT
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [4:0]      base_q;
  logic [31:0]     lane_buf [MAT_LANES];

  logic            mgrant;
  logic            load_buf;
  logic            wr_take;
  logic [4:0]      wr_addr;
  logic [31:0]     wr_data;

  // Grant and stall are forced low while reset is held, independent of clk.
  assign mgrant  = !rst && (state_q == IDLE) && m_valid &&
                   (!s_valid || (starve_q == STARVE_MAX));
  assign m_ready = mgrant;
  assign stall_o = !rst && ((state_q == MAT) || (mgrant && s_valid));
  assign busy    = (state_q == MAT);

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    starve_d = starve_q;
    load_buf = 1'b0;
    wr_take  = 1'b0;
    wr_addr  = rf_waddr;
    wr_data  = rf_wdata;
    case (state_q)
      IDLE: begin
        if (mgrant) begin
          wr_take  = 1'b1;
          wr_addr  = m_rd;
          wr_data  = m_data[31:0];
          starve_d = '0;
          if (MAT_LANES > 1) begin
            load_buf = 1'b1;
            beat_d   = BW'(1);
            state_d  = MAT;
          end
        end else begin
          if (m_valid && s_valid && (starve_q != STARVE_MAX))
            starve_d = starve_q + 1'b1;
          if (s_valid) begin
            wr_take = 1'b1;
            wr_addr = s_rd;
            wr_data = s_data;
          end
        end
      end
      MAT: begin
        wr_take = 1'b1;
        wr_addr = base_q + 5'(beat_q);
        wr_data = lane_buf[beat_q];
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      for (int unsigned i = 0; i < MAT_LANES; i++) lane_buf[i] <= '0;
    end else if (load_buf) begin
      base_q <= m_rd;
      for (int unsigned i = 0; i < MAT_LANES; i++) lane_buf[i] <= m_data[32*i +: 32];
    end
  end

  // Writes to x0 still move address/data; only the enable is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_take && (wr_addr != 5'd0);
      if (wr_take) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random
// traffic, compared against a queue-based model of the write port.
module tb_wb_port_arbiter;

  localparam int LANES = 4;
  localparam int LIMIT = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_valid;
  logic [4:0]            s_rd;
  logic [31:0]           s_data;
  logic                  m_valid;
  logic [4:0]            m_rd;
  logic [32*LANES-1:0]   m_data;
  logic                  m_ready;
  logic                  stall_o;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [31:0]           rf_wdata;
  logic                  busy;

  wb_port_arbiter #(.MAT_LANES(LANES), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_rd(s_rd), .s_data(s_data),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
    .stall_o(stall_o), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: pending matrix beats live in a queue; the port drains one per cycle.
  logic [4:0]  q_addr [$];
  logic [31:0] q_data [$];
  int          starve;
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit          last_grant, last_stall, obs_mready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_addr.delete();
    q_data.delete();
    starve = 0;
    e_we = 1'b0; e_addr = '0; e_data = '0;
    last_grant = 1'b0; last_stall = 1'b0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    e_we = (a != 5'd0);
    e_addr = a;
    e_data = d;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    bit in_mat, grant, stall;
    #1;
    in_mat = (q_addr.size() > 0);
    grant  = !in_mat && m_valid && (!s_valid || starve == LIMIT);
    stall  = in_mat || (grant && s_valid);
    check("m_ready", m_ready, grant);
    check("stall_o", stall_o, stall);
    check("busy", busy, in_mat);
    obs_mready = m_ready;
    last_grant = grant;
    last_stall = stall;
    if (grant) begin
      for (int k = 0; k < LANES; k++) begin
        q_addr.push_back(5'((m_rd + k) % 32));
        q_data.push_back(m_data[32*k +: 32]);
      end
      starve = 0;
    end else if (!in_mat && m_valid && s_valid && starve < LIMIT) begin
      starve++;
    end
    if (q_addr.size() > 0) model_write(q_addr.pop_front(), q_data.pop_front());
    else if (s_valid) model_write(s_rd, s_data);
    else e_we = 1'b0;
    @(posedge clk);
    #1;
    check("rf_we", rf_we, e_we);
    check("rf_waddr", rf_waddr, e_addr);
    check("rf_wdata", rf_wdata, e_data);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b1;
    m_valid = 1'b1;
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_m_ready", m_ready, 0);
    check("rst_stall_o", stall_o, 0);
    s_valid = 1'b0;
    m_valid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_mdata();
    for (int k = 0; k < LANES; k++) m_data[32*k +: 32] = $urandom;
  endtask

  task automatic rand_cycle();
    if (!(m_valid && !last_grant)) begin
      m_valid = ($urandom_range(0, 3) == 0);
      m_rd = 5'($urandom);
      rand_mdata();
    end
    if (!(s_valid && last_stall)) begin
      s_valid = 1'($urandom_range(0, 1));
      s_rd = 5'($urandom);
      s_data = $urandom;
    end
    cycle();
  endtask

  initial begin
    int gi, cnt, grants;
    rst = 1'b1;
    s_valid = 1'b0; s_rd = '0; s_data = '0;
    m_valid = 1'b0; m_rd = '0; m_data = '0;
    do_reset();

    // Scalar only, then scalar write to x0.
    s_valid = 1'b1; s_rd = 5'd5; s_data = 32'hDEADBEEF;
    cycle();
    check("s_only_we", rf_we, 1);
    check("s_only_addr", rf_waddr, 5);
    check("s_only_data", rf_wdata, 32'hDEADBEEF);
    s_rd = 5'd0; s_data = 32'h12345678;
    cycle();
    check("s_x0_we", rf_we, 0);
    s_valid = 1'b0;

    // Matrix only.
    m_valid = 1'b1; m_rd = 5'd8;
    m_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    for (int i = 0; i < LANES; i++) begin
      cycle();
      if (i == 0) check("m_only_ready", obs_mready, 1);
      m_valid = 1'b0;
      check("m_only_addr", rf_waddr, 32'(8 + i));
      check("m_only_data", rf_wdata, 32'h11111111 * (i + 1));
    end
    cycle();

    // Wrap through x0.
    m_valid = 1'b1; m_rd = 5'd30; rand_mdata();
    for (int i = 0; i < LANES; i++) begin
      cycle();
      m_valid = 1'b0;
      if (i == 2) check("wrap_x0_we", rf_we, 0);
    end

    // Contention: scalar every cycle, matrix waits out the starve limit.
    do_reset();
    m_valid = 1'b1; m_rd = 5'd12; rand_mdata();
    gi = -1;
    for (int i = 0; i < 14; i++) begin
      if (last_grant) m_valid = 1'b0;
      if (!last_stall) begin
        s_valid = 1'b1; s_rd = 5'(i + 1); s_data = $urandom;
      end
      cycle();
      if (obs_mready && gi < 0) gi = i;
    end
    check("contend_grant_cycle", gi, 8);
    s_valid = 1'b0; m_valid = 1'b0;
    cycle();

    // Reset in the middle of a burst.
    m_valid = 1'b1; m_rd = 5'd3; rand_mdata();
    cycle();
    m_valid = 1'b0;
    cycle();
    do_reset();
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (rf_we) cnt++;
    end
    check("abort_writes", cnt, 0);

    // Back-to-back matrix bursts with no bubble.
    m_valid = 1'b1; m_rd = 5'd16; rand_mdata();
    cnt = 0; grants = 0;
    for (int i = 0; i < 2 * LANES; i++) begin
      if (last_grant) begin
        grants++;
        if (grants == 1) begin
          m_rd = 5'd20; rand_mdata();
        end else begin
          m_valid = 1'b0;
        end
      end
      cycle();
      if (rf_we) cnt++;
    end
    check("b2b_writes", cnt, 2 * LANES);
    m_valid = 1'b0;
    cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) rand_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
